// File: rtl/decode_opc_phase1_pkg.sv
// decode_opc_phase1 shared constants
// prefix/escape codes, error codes, FSM states
package decode_opc_phase1_pkg;

  localparam logic [7:0] PFX_OPSIZE = 8'h66;
  localparam logic [7:0] PFX_REP_F3 = 8'hF3;
  localparam logic [7:0] PFX_REP_F2 = 8'hF2;
  localparam logic [7:0] PFX_LOCK   = 8'hF0;
  localparam logic [7:0] PFX_ES     = 8'h26;
  localparam logic [7:0] PFX_CS     = 8'h2E;
  localparam logic [7:0] PFX_SS     = 8'h36;
  localparam logic [7:0] PFX_DS     = 8'h3E;
  localparam logic [7:0] PFX_FS     = 8'h64;
  localparam logic [7:0] PFX_GS     = 8'h65;

  localparam logic [7:0] ESC_0F = 8'h0F;
  localparam logic [7:0] ESC_38 = 8'h38;
  localparam logic [7:0] ESC_3A = 8'h3A;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_TRUNC = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_ESC   = 2'b11;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_F3   = 2'b01;
  localparam logic [1:0] REP_F2   = 2'b10;

  localparam logic [2:0] PK_NONE   = 3'd0;
  localparam logic [2:0] PK_OPSIZE = 3'd1;
  localparam logic [2:0] PK_REP_F3 = 3'd2;
  localparam logic [2:0] PK_REP_F2 = 3'd3;
  localparam logic [2:0] PK_LOCK   = 3'd4;
  localparam logic [2:0] PK_SEG    = 3'd5;

  localparam logic [3:0] CNT_MAX  = 4'd15;
  localparam logic [3:0] BODY_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_PFX   = 3'd0,
    S_ESC   = 3'd1,
    S_BODY  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/decode_opc_phase1_classify.sv
// decode_prefix_classify: combinational byte classifier
// reports prefix kind, segment code and escape
module decode_prefix_classify
  import decode_opc_phase1_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_prefix,
  output logic [2:0] kind,
  output logic [2:0] seg,
  output logic       is_escape
);

  always_comb begin
    kind = PK_NONE;
    seg  = 3'd0;
    unique case (1'b1)
      data == PFX_OPSIZE: kind = PK_OPSIZE;
      data == PFX_REP_F3: kind = PK_REP_F3;
      data == PFX_REP_F2: kind = PK_REP_F2;
      data == PFX_LOCK:   kind = PK_LOCK;
      data == PFX_ES: begin kind = PK_SEG; seg = 3'd1; end
      data == PFX_CS: begin kind = PK_SEG; seg = 3'd2; end
      data == PFX_SS: begin kind = PK_SEG; seg = 3'd3; end
      data == PFX_DS: begin kind = PK_SEG; seg = 3'd4; end
      data == PFX_FS: begin kind = PK_SEG; seg = 3'd5; end
      data == PFX_GS: begin kind = PK_SEG; seg = 3'd6; end
      default: ;
    endcase
  end

  assign is_prefix = kind != PK_NONE;
  assign is_escape = data == ESC_0F;

endmodule

// File: rtl/decode_opc_phase1.sv
// decode_opc_phase1: strips prefixes/escape from the byte
// stream and assembles up to 9 body bytes per instruction
module decode_opc_phase1
  import decode_opc_phase1_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [71:0] unescaped_instr,
  output logic        is_2byte,
  output logic        pfx_opsize,
  output logic [1:0]  pfx_rep,
  output logic        pfx_lock,
  output logic [2:0]  pfx_seg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  err
);

  state_t      st_q, st_d;
  logic [71:0] instr_q;
  logic        two_q, opsz_q, lock_q;
  logic [1:0]  rep_q, err_q, new_err;
  logic [2:0]  seg_q, pk, pseg;
  logic [3:0]  cnt_q, bidx_q;
  logic        is_pfx, is_esc, esc_bad;
  logic        acc, too_long;

  decode_prefix_classify u_cls (
    .data      (in_byte),
    .is_prefix (is_pfx),
    .kind      (pk),
    .seg       (pseg),
    .is_escape (is_esc)
  );

  assign in_ready  = st_q != S_OUT;
  assign out_valid = st_q == S_OUT;
  assign acc       = in_valid & in_ready;
  assign esc_bad   = (in_byte == ESC_38) | (in_byte == ESC_3A);
  assign too_long  = (cnt_q == CNT_MAX) |
                     ((st_q == S_BODY) & (bidx_q == BODY_MAX));

  // once draining, the first error code sticks
  always_comb begin
    new_err = ERR_OK;
    if (st_q != S_DRAIN && st_q != S_OUT) begin
      if (too_long)
        new_err = ERR_LONG;
      else if (st_q == S_PFX && (is_pfx | is_esc) && in_last)
        new_err = ERR_TRUNC;
      else if (st_q == S_ESC && esc_bad)
        new_err = ERR_ESC;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_PFX, S_ESC, S_BODY: begin
        if (acc) begin
          if (in_last)
            st_d = S_OUT;
          else if (new_err != ERR_OK)
            st_d = S_DRAIN;
          else if (st_q != S_PFX)
            st_d = S_BODY;
          else if (is_esc)
            st_d = S_ESC;
          else if (!is_pfx)
            st_d = S_BODY;
        end
      end
      S_DRAIN: if (acc && in_last) st_d = S_OUT;
      S_OUT:   if (out_ready) st_d = S_PFX;
      default: st_d = S_PFX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_PFX;
    else        st_q <= st_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      two_q   <= 1'b0;
      opsz_q  <= 1'b0;
      rep_q   <= REP_NONE;
      lock_q  <= 1'b0;
      seg_q   <= 3'd0;
      err_q   <= ERR_OK;
      cnt_q   <= 4'd0;
      bidx_q  <= 4'd0;
    end else if (st_q == S_OUT) begin
      if (out_ready) begin
        instr_q <= '0;
        two_q   <= 1'b0;
        opsz_q  <= 1'b0;
        rep_q   <= REP_NONE;
        lock_q  <= 1'b0;
        seg_q   <= 3'd0;
        err_q   <= ERR_OK;
        cnt_q   <= 4'd0;
        bidx_q  <= 4'd0;
      end
    end else if (acc) begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 4'd1;
      if (new_err != ERR_OK) err_q <= new_err;
      if (st_q != S_DRAIN && !too_long) begin
        unique case (st_q)
          S_PFX: begin
            if (is_esc) begin
              two_q <= 1'b1;
            end else if (is_pfx) begin
              unique case (pk)
                PK_OPSIZE: opsz_q <= 1'b1;
                PK_REP_F3: rep_q  <= REP_F3;
                PK_REP_F2: rep_q  <= REP_F2;
                PK_LOCK:   lock_q <= 1'b1;
                PK_SEG:    seg_q  <= pseg;
                default: ;
              endcase
            end else begin
              instr_q[7:0] <= in_byte;
              bidx_q       <= 4'd1;
            end
          end
          S_ESC: begin
            if (!esc_bad) begin
              instr_q[7:0] <= in_byte;
              bidx_q       <= 4'd1;
            end
          end
          S_BODY: begin
            instr_q[{bidx_q, 3'b000} +: 8] <= in_byte;
            bidx_q <= bidx_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign unescaped_instr = instr_q;
  assign is_2byte        = two_q;
  assign pfx_opsize      = opsz_q;
  assign pfx_rep         = rep_q;
  assign pfx_lock        = lock_q;
  assign pfx_seg         = seg_q;
  assign err             = err_q;

endmodule

// File: tb/tb_decode_opc_phase1.sv
// tb_decode_opc_phase1: random instruction streams checked
// against a byte-rule model, plus directed corner cases
module tb_decode_opc_phase1;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [71:0] instr;
    logic        two;
    logic        opsz;
    logic [1:0]  rep;
    logic        lock;
    logic [2:0]  seg;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  in_byte = 0;
  logic        in_valid = 0;
  logic        in_last = 0;
  logic        in_ready;
  logic [71:0] unescaped_instr;
  logic        is_2byte, pfx_opsize, pfx_lock;
  logic [1:0]  pfx_rep, err;
  logic [2:0]  pfx_seg;
  logic        out_valid;
  logic        out_ready = 0;

  int checks = 0;
  int errors = 0;
  int hold_cnt = 0;
  bit held = 0;
  time last_t = 0;
  exp_t exp_q[$];

  logic [7:0] pfx_tab [10] = '{8'h66, 8'hF3, 8'hF2, 8'hF0,
    8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};

  decode_opc_phase1 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_byte         (in_byte),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .unescaped_instr (unescaped_instr),
    .is_2byte        (is_2byte),
    .pfx_opsize      (pfx_opsize),
    .pfx_rep         (pfx_rep),
    .pfx_lock        (pfx_lock),
    .pfx_seg         (pfx_seg),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [95:0] act,
                       input logic [95:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // instruction semantics from the byte rules alone
  function automatic exp_t model(input bq_t b);
    exp_t e;
    logic [71:0] ins;
    int mode, nbody;
    bit last;
    e = '0;
    ins = '0;
    mode = 0;
    nbody = 0;
    for (int i = 0; i < b.size(); i++) begin
      last = (i == b.size() - 1);
      if (e.err != 2'b00) continue;
      if (i >= 15 || nbody == 9) begin
        e.err = 2'b10;
        continue;
      end
      if (mode == 0) begin
        case (b[i])
          8'h66: e.opsz = 1;
          8'hF3: e.rep = 2'b01;
          8'hF2: e.rep = 2'b10;
          8'hF0: e.lock = 1;
          8'h26: e.seg = 3'd1;
          8'h2E: e.seg = 3'd2;
          8'h36: e.seg = 3'd3;
          8'h3E: e.seg = 3'd4;
          8'h64: e.seg = 3'd5;
          8'h65: e.seg = 3'd6;
          8'h0F: begin e.two = 1; mode = 1; end
          default: begin ins[7:0] = b[i]; nbody = 1; mode = 2; end
        endcase
        if (mode != 2 && last) e.err = 2'b01;
      end else if (mode == 1) begin
        if (b[i] == 8'h38 || b[i] == 8'h3A) e.err = 2'b11;
        else begin ins[7:0] = b[i]; nbody = 1; mode = 2; end
      end else begin
        ins[nbody*8 +: 8] = b[i];
        nbody++;
      end
    end
    e.instr = ins;
    return e;
  endfunction

  function automatic bq_t gen();
    bq_t q;
    int n, r;
    n = $urandom_range(1, 19);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)       q.push_back(pfx_tab[$urandom_range(0, 9)]);
      else if (r == 3) q.push_back(8'h0F);
      else if (r == 4) q.push_back($urandom_range(0, 1) ? 8'h38 : 8'h3A);
      else             q.push_back(8'($urandom_range(0, 255)));
    end
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    t = 0;
    while ($urandom_range(0, 3) == 0) begin
      in_valid = 0;
      in_byte = 8'($urandom_range(0, 255));
      in_last = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1;
    in_byte = b;
    in_last = last;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    if (last) last_t = $time;
    #1;
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic send_instr(input bq_t b);
    exp_q.push_back(model(b));
    foreach (b[i]) send_byte(b[i], i == b.size() - 1);
  endtask

  // compare process: sample on falling edge, drive out_ready
  initial begin
    exp_t e;
    logic [81:0] snap;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
        out_ready = 0;
        continue;
      end
      if (out_valid) begin
        check("in_ready_in_out", in_ready, 0);
        if (!held) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got out_valid 1 expected 0");
            e = '0;
          end else begin
            e = exp_q.pop_front();
          end
          check("instr", unescaped_instr, e.instr);
          check("is_2byte", is_2byte, e.two);
          check("pfx_opsize", pfx_opsize, e.opsz);
          check("pfx_rep", pfx_rep, e.rep);
          check("pfx_lock", pfx_lock, e.lock);
          check("pfx_seg", pfx_seg, e.seg);
          check("err", err, e.err);
          check("latency", $time - last_t, 5);
          held = 1;
        end else begin
          check("stable", {unescaped_instr, is_2byte, pfx_opsize,
                pfx_rep, pfx_lock, pfx_seg, err}, snap);
        end
        snap = {unescaped_instr, is_2byte, pfx_opsize,
                pfx_rep, pfx_lock, pfx_seg, err};
        if (hold_cnt > 0) begin
          out_ready = 0;
          hold_cnt--;
        end else begin
          out_ready = $urandom_range(0, 2) != 0;
        end
        if (out_ready) held = 0;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    bq_t b;
    exp_t m;
    #12 rst_n = 1;
    @(negedge clk);
    check("rst_instr", unescaped_instr, 0);
    check("rst_flags", {is_2byte, pfx_opsize, pfx_rep, pfx_lock,
          pfx_seg, err, out_valid}, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    b = '{8'h66, 8'h0F, 8'hAF, 8'hC3};
    m = model(b);
    check("pin32_instr", m.instr, 72'hC3AF);
    check("pin32_flags", {m.two, m.opsz, m.err}, 4'b1100);
    send_instr(b);

    b = '{8'hF3, 8'hF2, 8'h2E, 8'h64, 8'hA4};
    m = model(b);
    check("pin33", {m.rep, m.seg, m.instr}, {2'b10, 3'd5, 72'hA4});
    send_instr(b);

    b = '{8'h0F, 8'h38, 8'h11, 8'h22};
    check("pin34_esc", model(b).err, 2'b11);
    send_instr(b);

    b = '{8'h66};
    check("pin34_trunc", model(b).err, 2'b01);
    send_instr(b);

    b = {};
    for (int i = 1; i <= 12; i++) b.push_back(8'(i));
    m = model(b);
    check("pin34_long", {m.err, m.instr},
          {2'b10, 72'h090807060504030201});
    send_instr(b);

    b = {};
    for (int i = 0; i < 15; i++) b.push_back(8'h66);
    b.push_back(8'h90);
    check("pin_16bytes", model(b).err, 2'b10);
    send_instr(b);

    b = {};
    for (int i = 0; i < 6; i++) b.push_back(8'h3E);
    for (int i = 1; i <= 9; i++) b.push_back(8'(i));
    m = model(b);
    check("pin_15bytes", {m.err, m.seg}, {2'b00, 3'd4});
    send_instr(b);

    hold_cnt = 5;
    send_instr('{8'hF0, 8'h90, 8'h55});
    send_instr('{8'h65, 8'h0F, 8'h01, 8'h02});

    send_byte(8'h90, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    check("pre_rst_instr", unescaped_instr, 72'h020190);
    rst_n = 0;
    #1;
    check("mid_rst_instr", unescaped_instr, 0);
    check("mid_rst_flags", {is_2byte, pfx_opsize, pfx_rep, pfx_lock,
          pfx_seg, err, out_valid}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    send_instr('{8'h2E, 8'h8B, 8'h45, 8'h08});

    for (int n = 0; n < 300; n++) send_instr(gen());

    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
